reg_mst: RTL and testbench

- Register-access initiator that drives the simple register-slave interface used by the per-block register files (wen/waddr/wdata/wstrb/wrdy, ren/raddr/rdata/rrdy).
- Accepts one command at a time on a valid/ready command channel and issues a single-cycle wen or ren strobe.
- Waits for the slave's wrdy/rrdy, with a timeout, then returns a response on a valid/ready response channel.
- Sits between the host-side control path and the register slaves.

---
 rtl/reg_mst_pkg.sv | 18 +
 rtl/reg_mst_tmo.sv | 34 +++
 rtl/reg_mst.sv | 188 ++++++++++++++++++
 tb/tb_reg_mst.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_mst_pkg.sv
// Shared types and defaults for the reg_mst register-access initiator.
package reg_mst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  localparam int unsigned DEF_TIMEOUT_CYC = 16;
  localparam int unsigned DEF_POLL_MAX    = 64;

  localparam logic RSP_OK          = 1'b0;
  localparam logic RSP_ERR_TIMEOUT = 1'b1;

endpackage

// File: rtl/reg_mst_tmo.sv
// Clearable saturating up-counter with a compare-against-limit flag.
module reg_mst_tmo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             hit_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == limit_i);

endmodule

// File: rtl/reg_mst.sv
// Register-access initiator: one command -> one wen/ren strobe -> one response.
// Optional read polling is enabled by defining REG_MST_POLL_EN.
module reg_mst
  import reg_mst_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STRB_WIDTH   = 8,
  parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
  parameter int unsigned TO_CNT_WIDTH = 8
`ifdef REG_MST_POLL_EN
  ,
  parameter int unsigned POLL_MAX     = DEF_POLL_MAX
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  wrdy,
  output logic                  ren,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rrdy,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
`ifdef REG_MST_POLL_EN
  ,
  input  logic                  cmd_poll,
  input  logic [DATA_WIDTH-1:0] cmd_mask,
  input  logic [DATA_WIDTH-1:0] cmd_match
`endif
);

  state_e                state_q, state_d;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] waddr_q, raddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  accept, ack;
  logic                  tmo_clr, tmo_inc, tmo_hit;

  assign accept = cmd_valid && (state_q == ST_IDLE);
  // Only the ack matching the transaction direction counts.
  assign ack    = write_q ? wrdy : rrdy;

  reg_mst_tmo #(.WIDTH(TO_CNT_WIDTH)) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (tmo_clr),
    .inc_i   (tmo_inc),
    .limit_i (TO_CNT_WIDTH'(TIMEOUT_CYC - 1)),
    .hit_o   (tmo_hit)
  );

`ifdef REG_MST_POLL_EN
  localparam int unsigned PCW = $clog2(POLL_MAX + 1);

  logic                  poll_q;
  logic [DATA_WIDTH-1:0] mask_q, match_q;
  logic                  poll_inc, poll_hit;

  reg_mst_tmo #(.WIDTH(PCW)) u_poll (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (accept),
    .inc_i   (poll_inc),
    .limit_i (PCW'(POLL_MAX - 1)),
    .hit_o   (poll_hit)
  );
`endif

  always_comb begin
    state_d     = state_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    tmo_clr     = 1'b0;
    tmo_inc     = 1'b0;
`ifdef REG_MST_POLL_EN
    poll_inc    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        tmo_clr = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // An ack on the limit cycle still counts as success.
        if (ack) begin
          rsp_err_d   = RSP_OK;
          rsp_rdata_d = write_q ? '0 : rdata;
          state_d     = ST_RESP;
`ifdef REG_MST_POLL_EN
          if (poll_q && ((rdata & mask_q) != match_q)) begin
            if (poll_hit) begin
              rsp_err_d = RSP_ERR_TIMEOUT;
            end else begin
              poll_inc = 1'b1;
              state_d  = ST_GAP;
            end
          end
`endif
        end else if (tmo_hit) begin
          rsp_err_d   = RSP_ERR_TIMEOUT;
          rsp_rdata_d = '0;
          state_d     = ST_RESP;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      ST_GAP: begin
        state_d = ST_ISSUE;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      raddr_q     <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef REG_MST_POLL_EN
      poll_q      <= 1'b0;
      mask_q      <= '0;
      match_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (accept) begin
        write_q <= cmd_write;
        if (cmd_write) begin
          waddr_q <= cmd_addr;
          wdata_q <= cmd_wdata;
          wstrb_q <= cmd_wstrb;
        end else begin
          raddr_q <= cmd_addr;
        end
`ifdef REG_MST_POLL_EN
        poll_q  <= cmd_poll && !cmd_write;
        mask_q  <= cmd_mask;
        match_q <= cmd_match;
`endif
      end
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign wen       = (state_q == ST_ISSUE) && write_q;
  assign ren       = (state_q == ST_ISSUE) && !write_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign raddr     = raddr_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_write = write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_reg_mst.sv
// Self-checking bench for reg_mst: timeline model of each transaction plus literal pins.
module tb_reg_mst;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 8;
  localparam int TMO = 16;
  localparam int BIG = 1 << 30;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          wen, wrdy, ren, rrdy;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic          rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [DW-1:0] rsp_rdata;

  always #5 clk = ~clk;

  reg_mst #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .STRB_WIDTH   (SW),
    .TIMEOUT_CYC  (TMO),
    .TO_CNT_WIDTH (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wrdy      (wrdy),
    .ren       (ren),
    .raddr     (raddr),
    .rdata     (rdata),
    .rrdy      (rrdy),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: cycle windows of the current transaction and the held address/data outputs.
  int            t_acc = -10, t_rsp = -10, t_end = -10;
  bit            m_wr;
  bit            m_err;
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] cur_waddr, cur_raddr, pend_waddr, pend_raddr;
  logic [DW-1:0] cur_wdata, pend_wdata;
  logic [SW-1:0] cur_wstrb, pend_wstrb;
  int            pend_cyc = BIG;
  bit            chk_en = 1'b0;
  int            wen_cnt = 0;

  always @(negedge clk) if (wen === 1'b1) wen_cnt++;

  always @(negedge clk) begin
    int c;
    bit intx, erv;
    if (chk_en) begin
      c = cyc;
      if (c >= pend_cyc) begin
        cur_waddr = pend_waddr;
        cur_wdata = pend_wdata;
        cur_wstrb = pend_wstrb;
        cur_raddr = pend_raddr;
        pend_cyc  = BIG;
      end
      intx = (c >= t_acc) && (c < t_end);
      erv  = (c >= t_rsp) && (c < t_end);
      chk("cmd_ready", cmd_ready, !intx);
      chk("wen", wen, (c == t_acc) && m_wr);
      chk("ren", ren, (c == t_acc) && !m_wr);
      chk("rsp_valid", rsp_valid, erv);
      if (erv) begin
        chk("rsp_write", rsp_write, m_wr);
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", rsp_err, m_err);
      end
      chk("waddr", waddr, cur_waddr);
      chk("wdata", wdata, cur_wdata);
      chk("wstrb", wstrb, cur_wstrb);
      chk("raddr", raddr, cur_raddr);
    end
  end

  // d = slave ack delay after the strobe (0 = never); hold = cycles rsp_ready stays low.
  task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [SW-1:0] strb, input logic [DW-1:0] rd, input int d,
                         input int hold, input bit noisy, input int rst_at,
                         output int acc, output int lat, output logic [DW-1:0] cap_rdata,
                         output logic cap_err, output logic cap_write);
    int a, wend;
    bit to;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_wstrb = strb;
    @(posedge clk); #1;
    a         = cyc;
    acc       = a;
    lat       = -1;
    cap_rdata = 'x;
    cap_err   = 1'bx;
    cap_write = 1'bx;
    to        = (d == 0) || (d > TMO);
    wend      = to ? TMO - 1 : d - 1;
    m_wr      = wr;
    m_err     = to;
    m_rdata   = (wr || to) ? '0 : rd;
    t_acc     = a;
    t_rsp     = a + 2 + wend;
    t_end     = t_rsp + hold + 1;
    pend_waddr = wr ? addr : cur_waddr;
    pend_wdata = wr ? wd   : cur_wdata;
    pend_wstrb = wr ? strb : cur_wstrb;
    pend_raddr = wr ? cur_raddr : addr;
    pend_cyc   = a;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_wstrb = SW'($urandom);
    for (int c = a; c < t_end; c++) begin
      bit ackn;
      ackn      = (d > 0) && (c == a + d);
      wrdy      = (wr && ackn) || (noisy && (c == a || !wr));
      rrdy      = (!wr && ackn) || (noisy && (c == a || wr));
      rdata     = ackn ? rd : $urandom;
      rsp_ready = (c >= t_rsp + hold);
      if (rst_at > 0 && c == a + rst_at) begin
        reset      = 1'b1;
        t_end      = c + 1;
        t_rsp      = BIG;
        pend_waddr = '0;
        pend_wdata = '0;
        pend_wstrb = '0;
        pend_raddr = '0;
        pend_cyc   = c + 1;
        @(posedge clk); #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_ren", ren, 0);
        chk("rst_raddr", raddr, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        break;
      end
      if (lat < 0 && rsp_valid === 1'b1) begin
        lat       = c - a;
        cap_rdata = rsp_rdata;
        cap_err   = rsp_err;
        cap_write = rsp_write;
      end
      @(posedge clk); #1;
    end
    wrdy      = 1'b0;
    rrdy      = 1'b0;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int            acc, lat, a1, a2, a3, w0;
    logic [DW-1:0] rd_c;
    logic          err_c, wr_c;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; wrdy = 1'b0; rrdy = 1'b0; rdata = '0; rsp_ready = 1'b0;
    cur_waddr = '0; cur_wdata = '0; cur_wstrb = '0; cur_raddr = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_wen", wen, 0);
    chk("reset_rsp_write", rsp_write, 0);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;

    w0 = wen_cnt;
    run_txn(1, 32'h04, 32'hDEADBEEF, 8'hFF, '0, 1, 0, 0, 0, acc, lat, rd_c, err_c, wr_c);
    chk("t1_wen_pulses", wen_cnt - w0, 1);
    // Two edges after the accepting edge = three cycles counting the accept cycle.
    chk("t1_latency", lat, 2);
    chk("t1_err", err_c, 0);
    chk("t1_rdata", rd_c, 0);
    chk("t1_write", wr_c, 1);
    chk("t1_waddr", waddr, 32'h04);
    chk("t1_wdata", wdata, 32'hDEADBEEF);

    run_txn(0, 32'h08, '0, '0, 32'h0ABCDEF0, 1, 0, 0, 0, acc, lat, rd_c, err_c, wr_c);
    chk("t2_rdata", rd_c, 32'h0ABCDEF0);
    chk("t2_err", err_c, 0);
    chk("t2_write", wr_c, 0);
    chk("t2_waddr_held", waddr, 32'h04);

    run_txn(0, 32'h0C, '0, '0, 32'h11111111, 0, 0, 0, 0, acc, lat, rd_c, err_c, wr_c);
    chk("t3_tmo_latency", lat, 17);
    chk("t3_err", err_c, 1);
    chk("t3_rdata", rd_c, 0);

    run_txn(0, 32'h10, '0, '0, 32'h12345678, TMO + 1, 3, 0, 0, acc, lat, rd_c, err_c, wr_c);
    chk("t4_late_err", err_c, 1);
    chk("t4_late_rdata", rsp_rdata, 0);

    run_txn(1, 32'h14, 32'h01020304, 8'h3C, '0, TMO, 0, 0, 0, acc, lat, rd_c, err_c, wr_c);
    chk("t5_limit_latency", lat, 17);
    chk("t5_limit_ack_wins", err_c, 0);

    run_txn(0, 32'h18, '0, '0, 32'h55AA55AA, 1, 10, 0, 0, acc, lat, rd_c, err_c, wr_c);
    chk("t6_span", cyc - acc, 13);
    chk("t6_cmd_ready_after", cmd_ready, 1);
    chk("t6_rdata", rd_c, 32'h55AA55AA);

    w0 = wen_cnt;
    run_txn(1, 32'h1C, 32'hA5A5A5A5, 8'h0F, '0, 2, 0, 1, 0, acc, lat, rd_c, err_c, wr_c);
    chk("t7_noisy_wen_pulses", wen_cnt - w0, 1);
    chk("t7_noisy_wr_latency", lat, 3);
    run_txn(0, 32'h20, '0, '0, 32'hCAFEF00D, 3, 0, 1, 0, acc, lat, rd_c, err_c, wr_c);
    chk("t7_noisy_rdata", rd_c, 32'hCAFEF00D);

    run_txn(1, 32'h30, 32'h0000AAAA, 8'h01, '0, 1, 0, 0, 0, a1, lat, rd_c, err_c, wr_c);
    run_txn(0, 32'h34, '0, '0, 32'h0BADCAFE, 1, 0, 0, 0, a2, lat, rd_c, err_c, wr_c);
    run_txn(1, 32'h38, 32'h0000BBBB, 8'h80, '0, 1, 0, 0, 0, a3, lat, rd_c, err_c, wr_c);
    chk("t8_b2b_gap1", a2 - a1, 4);
    chk("t8_b2b_gap2", a3 - a2, 4);

    run_txn(0, 32'h24, '0, '0, 32'h77777777, 0, 0, 0, 4, acc, lat, rd_c, err_c, wr_c);
    chk("t9_no_rsp", lat, -1);
    run_txn(1, 32'h28, 32'h13579BDF, 8'hF0, '0, 1, 0, 0, 0, acc, lat, rd_c, err_c, wr_c);
    chk("t9_after_rst_latency", lat, 2);
    chk("t9_after_rst_err", err_c, 0);

    repeat (3) begin @(posedge clk); #1; end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
